// File: rtl/div_period_mon.sv
`default_nettype none
// ============================================================================
// Module   : div_period_mon
// Brief    : Divided-clock period and per-window edge-count monitor.
//            Optional err_cnt saturating counter under DIV_PERIOD_MON_ERRCNT_EN.
// Revision : 1.0
// ============================================================================
module div_period_mon #(
    parameter int WIN_LEN   = 87,
    parameter int EXP_EDGES = 10,
    parameter int PER_MIN   = 8,
    parameter int PER_MAX   = 9
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       div_in,
    output logic [3:0] period,
    output logic       period_vld,
    output logic       period_err,
    output logic [6:0] n_short,
    output logic [6:0] n_long,
    output logic [6:0] edge_cnt,
    output logic       win_done,
    output logic       win_err,
    output logic [7:0] err_cnt
);
    localparam int               WIN_W       = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] c_win_last  = WIN_W'(WIN_LEN - 1);
    localparam logic [3:0]       c_per_min   = 4'(PER_MIN);
    localparam logic [3:0]       c_per_max   = 4'(PER_MAX);
    localparam logic [6:0]       c_exp_edges = 7'(EXP_EDGES);

    function automatic logic [6:0] sat_inc(input logic [6:0] v, input logic inc);
        return (inc && (v != 7'h7f)) ? v + 7'd1 : v;
    endfunction

    logic             div_q;
    logic             armed_q;
    logic [3:0]       pcnt_q,      pcnt_d;
    logic [WIN_W-1:0] win_q,       win_d;
    logic [6:0]       run_edge_q,  run_edge_d;
    logic [6:0]       run_short_q, run_short_d;
    logic [6:0]       run_long_q,  run_long_d;
    logic [3:0]       period_q,    period_d;
    logic             period_vld_q, period_vld_d;
    logic             period_err_q, period_err_d;
    logic [6:0]       n_short_q,   n_short_d;
    logic [6:0]       n_long_q,    n_long_d;
    logic [6:0]       edge_cnt_q,  edge_cnt_d;
    logic             win_done_q,  win_done_d;
    logic             win_err_q,   win_err_d;

    logic       w_edge, w_meas, w_wrap, w_short, w_long;
    logic [6:0] w_edge_sum, w_short_sum, w_long_sum;

    always_comb begin
        w_edge      = div_in & ~div_q;
        w_meas      = w_edge & armed_q;
        w_wrap      = (win_q == c_win_last);
        w_short     = w_meas && (pcnt_q == c_per_min);
        w_long      = w_meas && (pcnt_q == c_per_max);
        // Sums include this cycle's activity so a wrap-cycle edge lands in the closing window.
        w_edge_sum  = sat_inc(run_edge_q, w_edge);
        w_short_sum = sat_inc(run_short_q, w_short);
        w_long_sum  = sat_inc(run_long_q, w_long);

        pcnt_d       = w_edge ? 4'd1 : ((pcnt_q == 4'hf) ? pcnt_q : pcnt_q + 4'd1);
        win_d        = w_wrap ? '0 : win_q + 1'b1;
        period_d     = w_meas ? pcnt_q : period_q;
        period_vld_d = w_meas;
        period_err_d = w_meas && ((pcnt_q < c_per_min) || (pcnt_q > c_per_max));

        run_edge_d   = w_wrap ? 7'd0 : w_edge_sum;
        run_short_d  = w_wrap ? 7'd0 : w_short_sum;
        run_long_d   = w_wrap ? 7'd0 : w_long_sum;
        edge_cnt_d   = w_wrap ? w_edge_sum  : edge_cnt_q;
        n_short_d    = w_wrap ? w_short_sum : n_short_q;
        n_long_d     = w_wrap ? w_long_sum  : n_long_q;
        win_done_d   = w_wrap;
        win_err_d    = w_wrap && (w_edge_sum != c_exp_edges);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_q        <= 1'b0;
            armed_q      <= 1'b0;
            pcnt_q       <= 4'd0;
            win_q        <= '0;
            run_edge_q   <= 7'd0;
            run_short_q  <= 7'd0;
            run_long_q   <= 7'd0;
            period_q     <= 4'd0;
            period_vld_q <= 1'b0;
            period_err_q <= 1'b0;
            n_short_q    <= 7'd0;
            n_long_q     <= 7'd0;
            edge_cnt_q   <= 7'd0;
            win_done_q   <= 1'b0;
            win_err_q    <= 1'b0;
        end else begin
            div_q        <= div_in;
            armed_q      <= armed_q | w_edge;
            pcnt_q       <= pcnt_d;
            win_q        <= win_d;
            run_edge_q   <= run_edge_d;
            run_short_q  <= run_short_d;
            run_long_q   <= run_long_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            period_err_q <= period_err_d;
            n_short_q    <= n_short_d;
            n_long_q     <= n_long_d;
            edge_cnt_q   <= edge_cnt_d;
            win_done_q   <= win_done_d;
            win_err_q    <= win_err_d;
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign period_err = period_err_q;
    assign n_short    = n_short_q;
    assign n_long     = n_long_q;
    assign edge_cnt   = edge_cnt_q;
    assign win_done   = win_done_q;
    assign win_err    = win_err_q;

`ifdef DIV_PERIOD_MON_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] w_err_sum;

    // Counts the registered error pulses, so err_cnt trails them by one cycle.
    always_comb begin
        w_err_sum = {1'b0, err_cnt_q} + 9'(period_err_q) + 9'(win_err_q);
        err_cnt_d = w_err_sum[8] ? 8'hff : w_err_sum[7:0];
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_period_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_period_mon
// Brief    : Scoreboard bench for div_period_mon (period, window, error count).
// Revision : 1.0
// ============================================================================
module tb_div_period_mon;
    localparam int WIN_LEN   = 87;
    localparam int EXP_EDGES = 10;
    localparam int PER_MIN   = 8;
    localparam int PER_MAX   = 9;
`ifdef DIV_PERIOD_MON_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       div_in = 1'b0;
    logic [3:0] period;
    logic       period_vld, period_err;
    logic [6:0] n_short, n_long, edge_cnt;
    logic       win_done, win_err;
    logic [7:0] err_cnt;

    div_period_mon #(
        .WIN_LEN  (WIN_LEN),
        .EXP_EDGES(EXP_EDGES),
        .PER_MIN  (PER_MIN),
        .PER_MAX  (PER_MAX)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .div_in    (div_in),
        .period    (period),
        .period_vld(period_vld),
        .period_err(period_err),
        .n_short   (n_short),
        .n_long    (n_long),
        .edge_cnt  (edge_cnt),
        .win_done  (win_done),
        .win_err   (win_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         due;
        logic [3:0] per;
        logic       err;
    } per_t;

    typedef struct {
        int         due;
        logic [6:0] ec;
        logic [6:0] ns;
        logic [6:0] nl;
        logic       err;
    } win_t;

    per_t q_per[$];
    win_t q_win[$];
    per_t mp;
    win_t mw;

    int n_checks    = 0;
    int n_pass      = 0;
    int n_perr_seen = 0;
    int pe_cnt      = 0;

    // Reference state driven alongside the stimulus.
    int c, m_last, m_edge, m_short, m_long;
    bit m_prev, m_armed;

    always @(posedge clk_in) pe_cnt <= pe_cnt + 1;

    task automatic model_reset();
        c = 0; m_last = 0; m_edge = 0; m_short = 0; m_long = 0;
        m_prev = 1'b0; m_armed = 1'b0;
    endtask

    task automatic drive_cycle(input logic d);
        int   p;
        per_t e;
        win_t w;
        div_in = d;
        if (d && !m_prev) begin
            if (m_armed) begin
                p = ((c - m_last) > 15) ? 15 : (c - m_last);
                e.due = pe_cnt + 1;
                e.per = 4'(p);
                e.err = (p < PER_MIN) || (p > PER_MAX);
                q_per.push_back(e);
                if (p == PER_MIN) m_short = (m_short < 127) ? m_short + 1 : 127;
                if (p == PER_MAX) m_long  = (m_long  < 127) ? m_long  + 1 : 127;
            end
            m_armed = 1'b1;
            m_last  = c;
            m_edge  = (m_edge < 127) ? m_edge + 1 : 127;
        end
        m_prev = d;
        if ((c % WIN_LEN) == WIN_LEN - 1) begin
            w.due = pe_cnt + 1;
            w.ec  = 7'(m_edge);
            w.ns  = 7'(m_short);
            w.nl  = 7'(m_long);
            w.err = (m_edge != EXP_EDGES);
            q_win.push_back(w);
            m_edge = 0; m_short = 0; m_long = 0;
        end
        c++;
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_period(input int p);
        drive_cycle(1'b1);
        for (int i = 1; i < p; i++) drive_cycle(1'b0);
    endtask

    task automatic drive_pattern();
        for (int i = 0; i < 3; i++) drive_period(8);
        for (int i = 0; i < 7; i++) drive_period(9);
    endtask

    // Scoreboard: expected pulses are popped when the DUT reports them.
    always @(negedge clk_in) begin
        if (!rst) begin
            if (period_vld) begin
                n_checks++;
                if (q_per.size() > 0 && q_per[0].due == pe_cnt) begin
                    mp = q_per.pop_front();
                    if (period !== mp.per || period_err !== mp.err)
                        $display("FAIL period_sb: got period=%0d err=%0b, want period=%0d err=%0b",
                                 period, period_err, mp.per, mp.err);
                    else n_pass++;
                end else begin
                    $display("FAIL period_sb: got unexpected period_vld period=%0d, want no pulse", period);
                end
            end else if (q_per.size() > 0 && q_per[0].due <= pe_cnt) begin
                n_checks++;
                mp = q_per.pop_front();
                $display("FAIL period_sb: got period_vld=0, want pulse with period=%0d", mp.per);
            end
            n_checks++;
            if (period_err && !period_vld)
                $display("FAIL period_err_alone: got period_err=1 period_vld=0, want coincident");
            else n_pass++;
            if (period_err) n_perr_seen++;

            if (win_done) begin
                n_checks++;
                if (q_win.size() > 0 && q_win[0].due == pe_cnt) begin
                    mw = q_win.pop_front();
                    if (edge_cnt !== mw.ec || n_short !== mw.ns || n_long !== mw.nl || win_err !== mw.err)
                        $display("FAIL window_sb: got edges=%0d short=%0d long=%0d err=%0b, want %0d %0d %0d %0b",
                                 edge_cnt, n_short, n_long, win_err, mw.ec, mw.ns, mw.nl, mw.err);
                    else n_pass++;
                end else begin
                    $display("FAIL window_sb: got unexpected win_done, want no pulse");
                end
            end else if (q_win.size() > 0 && q_win[0].due <= pe_cnt) begin
                n_checks++;
                mw = q_win.pop_front();
                $display("FAIL window_sb: got win_done=0, want pulse with edges=%0d", mw.ec);
            end
            n_checks++;
            if (win_err && !win_done)
                $display("FAIL win_err_alone: got win_err=1 win_done=0, want coincident");
            else n_pass++;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        div_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if ({period, period_vld, period_err, n_short, n_long, edge_cnt, win_done, win_err, err_cnt} !== 37'd0)
            $display("FAIL reset_outputs: got %h, want 0",
                     {period, period_vld, period_err, n_short, n_long, edge_cnt, win_done, win_err, err_cnt});
        else n_pass++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_clean_pattern();
        int perr0;
        perr0 = n_perr_seen;
        for (int k = 0; k < 4; k++) begin
            drive_pattern();
            n_checks++;
            if (win_done !== 1'b1 || edge_cnt !== 7'd10 || n_short !== 7'd3 ||
                n_long !== ((k == 0) ? 7'd6 : 7'd7) || win_err !== 1'b0)
                $display("FAIL clean_window%0d: got done=%0b edges=%0d short=%0d long=%0d err=%0b, want 1 10 3 %0d 0",
                         k, win_done, edge_cnt, n_short, n_long, win_err, (k == 0) ? 6 : 7);
            else n_pass++;
        end
        n_checks++;
        if (n_perr_seen != perr0)
            $display("FAIL clean_no_period_err: got %0d pulses, want 0", n_perr_seen - perr0);
        else n_pass++;
    endtask

    task automatic test_short_period();
        drive_period(8);
        drive_period(7);
        drive_cycle(1'b1);
        n_checks++;
        if (period_vld !== 1'b1 || period !== 4'd7 || period_err !== 1'b1)
            $display("FAIL short_period: got vld=%0b period=%0d err=%0b, want 1 7 1", period_vld, period, period_err);
        else n_pass++;
        drive_cycle(1'b0);
        n_checks++;
        if (period_err !== 1'b0)
            $display("FAIL short_err_pulse_width: got period_err=%0b, want 0", period_err);
        else n_pass++;
        for (int i = 0; i < 6; i++) drive_cycle(1'b0);
        for (int i = 0; i < 7; i++) drive_period(9);
    endtask

    task automatic test_wrap_edge();
        drive_cycle(1'b1);
        n_checks++;
        if (win_done !== 1'b1 || edge_cnt !== 7'd11 || win_err !== 1'b1)
            $display("FAIL wrap_edge_closing: got done=%0b edges=%0d err=%0b, want 1 11 1", win_done, edge_cnt, win_err);
        else n_pass++;
        for (int i = 0; i < 7; i++) drive_cycle(1'b0);
        for (int i = 0; i < 2; i++) drive_period(8);
        for (int i = 0; i < 7; i++) drive_period(9);
        drive_cycle(1'b1);
        n_checks++;
        if (win_done !== 1'b1 || edge_cnt !== 7'd10 || win_err !== 1'b0)
            $display("FAIL wrap_edge_next: got done=%0b edges=%0d err=%0b, want 1 10 0", win_done, edge_cnt, win_err);
        else n_pass++;
        drive_cycle(1'b0);
        n_checks++;
        if (err_cnt !== (ERRCNT_ON ? 8'd2 : 8'd0))
            $display("FAIL err_cnt_short: got %0d, want %0d", err_cnt, ERRCNT_ON ? 2 : 0);
        else n_pass++;
    endtask

    task automatic test_stuck_low();
        for (int i = 0; i < 40; i++) drive_cycle(1'b0);
        drive_cycle(1'b1);
        n_checks++;
        if (period_vld !== 1'b1 || period !== 4'd15 || period_err !== 1'b1)
            $display("FAIL stuck_low: got vld=%0b period=%0d err=%0b, want 1 15 1", period_vld, period, period_err);
        else n_pass++;
        drive_cycle(1'b0);
    endtask

    task automatic test_reset_midwindow();
        while ((c % WIN_LEN) != 40) drive_cycle(1'b0);
        @(negedge clk_in);
        #1;
        rst = 1'b1;
        div_in = 1'b0;
        q_per.delete();
        q_win.delete();
        #1;
        n_checks++;
        if ({period, period_vld, period_err, n_short, n_long, edge_cnt, win_done, win_err, err_cnt} !== 37'd0)
            $display("FAIL midreset_async: got %h, want 0",
                     {period, period_vld, period_err, n_short, n_long, edge_cnt, win_done, win_err, err_cnt});
        else n_pass++;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if ({period, period_vld, period_err, n_short, n_long, edge_cnt, win_done, win_err, err_cnt} !== 37'd0)
            $display("FAIL midreset_held: got %h, want 0",
                     {period, period_vld, period_err, n_short, n_long, edge_cnt, win_done, win_err, err_cnt});
        else n_pass++;
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= WIN_LEN; k++) begin
            drive_cycle(k == 6);
            if (k == 6) begin
                n_checks++;
                if (period_vld !== 1'b0)
                    $display("FAIL midreset_arm_only: got period_vld=%0b, want 0", period_vld);
                else n_pass++;
            end
            if (k == WIN_LEN - 1) begin
                n_checks++;
                if (win_done !== 1'b0)
                    $display("FAIL midreset_early_done: got win_done=%0b at cycle %0d, want 0", win_done, k);
                else n_pass++;
            end
        end
        n_checks++;
        if (win_done !== 1'b1 || edge_cnt !== 7'd1 || win_err !== 1'b1)
            $display("FAIL midreset_first_window: got done=%0b edges=%0d err=%0b, want 1 1 1", win_done, edge_cnt, win_err);
        else n_pass++;
    endtask

    task automatic test_err_sat();
        for (int i = 0; i < 301; i++) drive_period(3);
        drive_cycle(1'b0);
        n_checks++;
        if (err_cnt !== (ERRCNT_ON ? 8'd255 : 8'd0))
            $display("FAIL err_cnt_sat: got %0d, want %0d", err_cnt, ERRCNT_ON ? 255 : 0);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_pattern();
        test_short_period();
        test_wrap_edge();
        test_stuck_low();
        test_reset_midwindow();
        test_err_sat();
        repeat (2) @(posedge clk_in);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
